// File: rtl/stage4_mem_pkg.sv
// Shared definitions for the MEM stage: inter-stage bus widths, load-op
// encodings and the packed layouts of the EX->MEM, MEM->WB and MEM->ID buses.
package stage4_mem_pkg;

  localparam int unsigned WIDTH_ES_TO_MS_BUS = 74;
  localparam int unsigned WIDTH_MS_TO_WS_BUS = 70;
  localparam int unsigned WIDTH_MS_TO_DS_BUS = 38;

  // Load operation encodings carried on es_to_ms_bus[73:71]
  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_H  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  // EX->MEM payload, MSB first: [73:71] ld_op ... [31:0] pc
  typedef struct packed {
    logic [2:0]  ld_op;
    logic [31:0] alu_result;
    logic [4:0]  dest;
    logic        res_from_mem;
    logic        gr_we;
    logic [31:0] pc;
  } es_to_ms_t;

  // MEM->WB payload, MSB first: [69:38] final_result ... [31:0] pc
  typedef struct packed {
    logic [31:0] final_result;
    logic [4:0]  dest;
    logic        gr_we;
    logic [31:0] pc;
  } ms_to_ws_t;

  // MEM->ID forwarding payload: {gr_we & valid, dest, final_result}
  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
  } ms_to_ds_t;

endpackage

// File: rtl/stage4_mem_load_align.sv
// Load data alignment: selects the byte/halfword addressed by addr_i from the
// SRAM word and sign- or zero-extends it according to ld_op_i.
// Ports:
//   ld_op_i  - load operation encoding
//   addr_i   - low two bits of the load address
//   rdata_i  - 32-bit word read from the data SRAM
//   result_o - aligned, extended load result (combinational)
module stage4_mem_load_align
  import stage4_mem_pkg::*;
(
  input  logic [2:0]  ld_op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte lane select
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
  end

  // Halfword select; addr_i[0] is deliberately ignored (no misalignment trap)
  assign half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Extension; unused encodings fall back to a full-word load
  always_comb begin
    result_o = rdata_i;
    case (ld_op_i)
      LD_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   result_o = {24'h0, byte_sel};
      LD_H:    result_o = {{16{half_sel[15]}}, half_sel};
      LD_HU:   result_o = {16'h0, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/stage4_mem.sv
// Memory-access stage of the 5-stage pipeline. Accepts instructions from EX,
// consumes the synchronous data-SRAM read word, aligns load data, holds that
// word across WB back-pressure, and drives the WB and ID-forwarding buses.
// Ports:
//   clk, resetn      - clock, synchronous active-low reset
//   es_to_ms_valid   - EX presents a valid instruction
//   ms_allow_in      - MEM accepts this cycle
//   es_to_ms_bus     - EX->MEM payload
//   data_sram_rdata  - SRAM read word, valid the cycle after EX issued it
//   ws_allow_in      - WB accepts this cycle
//   ms_to_ws_valid   - MEM presents a valid instruction to WB
//   ms_to_ws_bus     - MEM->WB payload
//   ms_to_ds_bus     - forwarding payload to ID
module stage4_mem
  import stage4_mem_pkg::*;
#(
  parameter int unsigned ES_TO_MS_W = WIDTH_ES_TO_MS_BUS,
  parameter int unsigned MS_TO_WS_W = WIDTH_MS_TO_WS_BUS,
  parameter int unsigned MS_TO_DS_W = WIDTH_MS_TO_DS_BUS
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  es_to_ms_valid,
  output logic                  ms_allow_in,
  input  logic [ES_TO_MS_W-1:0] es_to_ms_bus,
  input  logic [31:0]           data_sram_rdata,
  input  logic                  ws_allow_in,
  output logic                  ms_to_ws_valid,
  output logic [MS_TO_WS_W-1:0] ms_to_ws_bus,
  output logic [MS_TO_DS_W-1:0] ms_to_ds_bus
);

  logic        ms_valid_q, ms_valid_d;
  es_to_ms_t   bus_q, bus_d;
  logic        first_cycle_q, first_cycle_d;
  logic [31:0] rdata_hold_q, rdata_hold_d;

  logic        ms_ready_go;
  logic        accept;
  logic [31:0] rdata_sel;
  logic [31:0] load_data;
  logic [31:0] final_result;
  ms_to_ws_t   ws_bus;
  ms_to_ds_t   ds_bus;

  // Handshake: MEM never stalls on its own
  assign ms_ready_go    = 1'b1;
  assign ms_allow_in    = !ms_valid_q || (ms_ready_go && ws_allow_in);
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
  assign accept         = ms_allow_in && es_to_ms_valid;

  // Next-state: bus register is only written on a real transfer, never cleared
  always_comb begin
    ms_valid_d    = ms_valid_q;
    bus_d         = bus_q;
    first_cycle_d = accept;
    rdata_hold_d  = rdata_hold_q;
    if (ms_allow_in) begin
      ms_valid_d = es_to_ms_valid;
    end
    if (accept) begin
      bus_d = es_to_ms_t'(es_to_ms_bus);
    end
    // SRAM word is only live in the first MEM cycle; capture it for stalls
    if (first_cycle_q) begin
      rdata_hold_d = data_sram_rdata;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid_q    <= 1'b0;
      bus_q         <= '0;
      first_cycle_q <= 1'b0;
      rdata_hold_q  <= 32'h0;
    end else begin
      ms_valid_q    <= ms_valid_d;
      bus_q         <= bus_d;
      first_cycle_q <= first_cycle_d;
      rdata_hold_q  <= rdata_hold_d;
    end
  end

  assign rdata_sel = first_cycle_q ? data_sram_rdata : rdata_hold_q;

  stage4_mem_load_align u_load_align (
    .ld_op_i  (bus_q.ld_op),
    .addr_i   (bus_q.alu_result[1:0]),
    .rdata_i  (rdata_sel),
    .result_o (load_data)
  );

  assign final_result = bus_q.res_from_mem ? load_data : bus_q.alu_result;

  // Output buses; forwarding write-enable is gated so ID never matches a bubble
  always_comb begin
    ws_bus.final_result = final_result;
    ws_bus.dest         = bus_q.dest;
    ws_bus.gr_we        = bus_q.gr_we;
    ws_bus.pc           = bus_q.pc;
    ds_bus.gr_we        = bus_q.gr_we && ms_valid_q;
    ds_bus.dest         = bus_q.dest;
    ds_bus.final_result = final_result;
  end

  assign ms_to_ws_bus = ws_bus;
  assign ms_to_ds_bus = ds_bus;

endmodule

// File: tb/tb_stage4_mem.sv
// Testbench for stage4_mem: table of load/ALU vectors applied back-to-back and
// under random WB back-pressure, plus hand-written reset, bubble and stall
// sequences. Expected WB payloads are queued on acceptance and compared while
// the instruction sits in MEM.
module tb_stage4_mem;

  logic        clk;
  logic        resetn;
  logic        es_to_ms_valid;
  logic        ms_allow_in;
  logic [73:0] es_to_ms_bus;
  logic [31:0] data_sram_rdata;
  logic        ws_allow_in;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [37:0] ms_to_ds_bus;

  stage4_mem dut (
    .clk             (clk),
    .resetn          (resetn),
    .es_to_ms_valid  (es_to_ms_valid),
    .ms_allow_in     (ms_allow_in),
    .es_to_ms_bus    (es_to_ms_bus),
    .data_sram_rdata (data_sram_rdata),
    .ws_allow_in     (ws_allow_in),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .ms_to_ds_bus    (ms_to_ds_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        gr_we;
    logic        rfm;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [2:0]  ld_op;
    logic [31:0] rdata;
    logic [31:0] res;
  } vec_t;

  vec_t        vecs[$];
  logic [69:0] sb_q[$];
  int          n_checks;
  int          n_errors;
  bit          exp_valid;
  bit          acc_prev;
  bit          last_acc;
  bit          zero_idle;
  logic [31:0] rd_prev;

  function automatic vec_t mk(input logic [31:0] pc, input logic gr_we, input logic rfm,
                              input logic [4:0] dest, input logic [31:0] alu,
                              input logic [2:0] op, input logic [31:0] rd,
                              input logic [31:0] res);
    vec_t v;
    v.pc = pc; v.gr_we = gr_we; v.rfm = rfm; v.dest = dest;
    v.alu = alu; v.ld_op = op; v.rdata = rd; v.res = res;
    return v;
  endfunction

  task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check #1 later, update the model
  task automatic cycle(input bit ev, input vec_t v, input bit wa);
    logic [69:0] e;
    bit          allow;
    @(negedge clk);
    es_to_ms_valid  = ev;
    es_to_ms_bus    = {v.ld_op, v.alu, v.dest, v.rfm, v.gr_we, v.pc};
    ws_allow_in     = wa;
    data_sram_rdata = acc_prev ? rd_prev : (zero_idle ? 32'h0 : 32'($urandom()));
    #1;
    allow = !exp_valid || wa;
    chk("ms_allow_in", 74'(ms_allow_in), 74'(allow));
    chk("ms_to_ws_valid", 74'(ms_to_ws_valid), 74'(exp_valid));
    if (exp_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard: got valid instruction, expected none queued");
      end else begin
        e = sb_q[0];
        chk("ms_to_ws_bus", 74'(ms_to_ws_bus), 74'(e));
        chk("ms_to_ds_bus", 74'(ms_to_ds_bus), 74'({e[32], e[37:33], e[69:38]}));
      end
    end else begin
      chk("ds_gr_we_bubble", 74'(ms_to_ds_bus[37]), 74'b0);
    end
    if (exp_valid && wa) void'(sb_q.pop_front());
    last_acc = allow && ev;
    if (allow) exp_valid = ev;
    acc_prev = last_acc;
    if (last_acc) begin
      sb_q.push_back({v.res, v.dest, v.gr_we, v.pc});
      rd_prev = v.rdata;
    end
  endtask

  // Reset for n edges with EX pushing garbage, then check the reset state
  task automatic do_reset(input int n);
    @(negedge clk);
    resetn          = 1'b0;
    es_to_ms_valid  = 1'b1;
    es_to_ms_bus    = 74'({$urandom(), $urandom(), $urandom()});
    ws_allow_in     = 1'b0;
    data_sram_rdata = 32'($urandom());
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_ms_to_ws_valid", 74'(ms_to_ws_valid), 74'b0);
    chk("rst_ms_to_ds_bus", 74'(ms_to_ds_bus), 74'b0);
    chk("rst_ms_to_ws_bus", 74'(ms_to_ws_bus), 74'b0);
    chk("rst_ms_allow_in", 74'(ms_allow_in), 74'b1);
    es_to_ms_valid = 1'b0;
    resetn         = 1'b1;
    exp_valid      = 1'b0;
    acc_prev       = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    vec_t vs;
    vec_t idle;
    int   tries;
    n_checks = 0; n_errors = 0;
    exp_valid = 0; acc_prev = 0; last_acc = 0; zero_idle = 0; rd_prev = 32'h0;
    resetn = 1'b0; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
    ws_allow_in = 1'b1; data_sram_rdata = 32'h0;

    // {pc, gr_we, res_from_mem, dest, alu/addr, ld_op, rdata, expected final_result}
    vecs.push_back(mk(32'h1c000010, 1, 0, 5'd5,  32'h12345678, 3'b000, 32'hAAAAAAAA, 32'h12345678));
    vecs.push_back(mk(32'h1c000104, 1, 1, 5'd1,  32'h1c008003, 3'b001, 32'h80FF7F01, 32'hFFFFFF80));
    vecs.push_back(mk(32'h1c000108, 1, 1, 5'd2,  32'h1c008000, 3'b000, 32'hDEADBEEF, 32'hDEADBEEF));
    vecs.push_back(mk(32'h1c00010c, 1, 1, 5'd3,  32'h1c008003, 3'b011, 32'h80FF7F01, 32'h00000080));
    vecs.push_back(mk(32'h1c000110, 1, 1, 5'd4,  32'h1c008001, 3'b001, 32'h12345678, 32'h00000056));
    vecs.push_back(mk(32'h1c000114, 1, 1, 5'd6,  32'h1c008000, 3'b001, 32'h80FF7F01, 32'h00000001));
    vecs.push_back(mk(32'h1c000118, 1, 1, 5'd7,  32'h1c008002, 3'b100, 32'hCAFEF00D, 32'h0000CAFE));
    vecs.push_back(mk(32'h1c00011c, 1, 1, 5'd8,  32'h1c008002, 3'b010, 32'h80FF7F01, 32'hFFFF80FF));
    vecs.push_back(mk(32'h1c000120, 1, 1, 5'd9,  32'h1c008001, 3'b010, 32'h1234F00D, 32'hFFFFF00D));
    vecs.push_back(mk(32'h1c000124, 1, 1, 5'd10, 32'h1c008000, 3'b100, 32'h80FF7F01, 32'h00007F01));
    vecs.push_back(mk(32'h1c000128, 1, 1, 5'd11, 32'h1c008003, 3'b101, 32'hA5A5A5A5, 32'hA5A5A5A5));
    vecs.push_back(mk(32'h1c00012c, 1, 1, 5'd12, 32'h1c008002, 3'b011, 32'h80FF7F01, 32'h000000FF));
    vecs.push_back(mk(32'h1c000130, 0, 0, 5'd13, 32'hCAFEBABE, 3'b001, 32'h00000000, 32'hCAFEBABE));
    vecs.push_back(mk(32'h1c000134, 1, 1, 5'd14, 32'h1c008003, 3'b010, 32'h80FF7F01, 32'hFFFF80FF));
    vecs.push_back(mk(32'h1c000138, 1, 1, 5'd15, 32'h1c008002, 3'b100, 32'h80FF7F01, 32'h000080FF));
    vecs.push_back(mk(32'h1c00013c, 1, 1, 5'd31, 32'h1c008002, 3'b001, 32'h00800000, 32'hFFFFFF80));
    idle = vecs[0];

    // Reset with EX valid held high
    do_reset(2);

    // Back-to-back pass, WB always ready
    foreach (vecs[i]) cycle(1, vecs[i], 1);
    repeat (2) cycle(0, idle, 1);

    // Bubble after a gr_we=1 instruction
    cycle(1, vecs[0], 1);
    cycle(0, idle, 1);
    cycle(0, idle, 1);

    // Stall hold: ld.w, WB blocked 3 cycles while SRAM data drops to zero,
    // then drain and fill in the same cycle
    vs = mk(32'h1c000200, 1, 1, 5'd20, 32'h1c009000, 3'b000, 32'hDEADBEEF, 32'hDEADBEEF);
    cycle(1, vs, 1);
    zero_idle = 1;
    repeat (3) cycle(1, vecs[3], 0);
    cycle(1, vecs[3], 1);
    cycle(0, idle, 1);
    cycle(0, idle, 1);
    zero_idle = 0;

    // Random WB back-pressure; EX holds each vector until accepted
    foreach (vecs[i]) begin
      tries = 0;
      do begin
        cycle(1, vecs[i], 1'($urandom_range(0, 1)));
        tries++;
      end while (!last_acc && tries < 64);
      if (!last_acc) begin
        n_checks++;
        n_errors++;
        $display("FAIL accept_timeout: vector %0d got no acceptance, expected within 64 cycles", i);
      end
    end
    repeat (3) cycle(0, idle, 1);

    // Reset while an instruction is held under back-pressure
    cycle(1, vecs[1], 1);
    cycle(0, idle, 0);
    do_reset(1);
    cycle(1, vecs[2], 1);
    repeat (2) cycle(0, idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
